// File: rtl/eth_sb_apb_pkg.sv
// Shared types and defaults for the ETH sideband APB initiator.
// Holds the FSM state encoding and the request bundle layout.
package eth_sb_apb_pkg;

  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_e;

  typedef struct packed {
    logic                          write;
    logic [DEF_ADDR_WIDTH-1:0]     addr;
    logic [DEF_DATA_WIDTH-1:0]     wdata;
    logic [DEF_DATA_WIDTH/8-1:0]   strb;
  } req_t;

endpackage

// File: rtl/eth_sb_apb_master_fsm.sv
// Sideband APB initiator: single-beat requests to SETUP/ACCESS
// transfers, with a per-transfer ACCESS timeout.
module eth_sb_apb_master_fsm
  import eth_sb_apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_write,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [DATA_WIDTH-1:0]   i_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_req_strb,
  output logic                    o_resp_valid,
  input  logic                    i_resp_ready,
  output logic [DATA_WIDTH-1:0]   o_resp_rdata,
  output logic                    o_resp_slverr,
  output logic                    o_resp_timeout,
  output logic                    o_psel,
  output logic                    o_penable,
  output logic                    o_pwrite,
  output logic [ADDR_WIDTH-1:0]   o_paddr,
  output logic [DATA_WIDTH-1:0]   o_pwdata,
  output logic [DATA_WIDTH/8-1:0] o_pstrb,
  input  logic                    i_pready,
  input  logic                    i_pslverr,
  input  logic [DATA_WIDTH-1:0]   i_prdata
);

  localparam bit TO_EN = TIMEOUT_CYCLES > 0;
  localparam int CW =
    TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TERM =
    TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

  apb_mst_state_e state;
  logic [CW-1:0]  cnt;

  // Gated by reset so every output reads 0 while held in reset.
  assign o_req_ready = (state == IDLE) && i_reset_n;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      o_psel         <= 1'b0;
      o_penable      <= 1'b0;
      o_pwrite       <= 1'b0;
      o_paddr        <= '0;
      o_pwdata       <= '0;
      o_pstrb        <= '0;
      o_resp_valid   <= 1'b0;
      o_resp_rdata   <= '0;
      o_resp_slverr  <= 1'b0;
      o_resp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            state     <= SETUP;
            o_psel    <= 1'b1;
            o_penable <= 1'b0;
            o_pwrite  <= i_req_write;
            o_paddr   <= i_req_addr;
            o_pwdata  <= i_req_write ? i_req_wdata : '0;
            o_pstrb   <= i_req_write ? i_req_strb : '0;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          o_penable <= 1'b1;
          cnt       <= '0;
        end
        ACCESS: begin
          if (i_pready) begin
            state          <= RESP;
            o_psel         <= 1'b0;
            o_penable      <= 1'b0;
            o_resp_valid   <= 1'b1;
            o_resp_rdata   <= o_pwrite ? '0 : i_prdata;
            o_resp_slverr  <= i_pslverr;
            o_resp_timeout <= 1'b0;
          end else if (TO_EN && cnt == TERM) begin
            state          <= RESP;
            o_psel         <= 1'b0;
            o_penable      <= 1'b0;
            o_resp_valid   <= 1'b1;
            o_resp_rdata   <= '0;
            o_resp_slverr  <= 1'b1;
            o_resp_timeout <= 1'b1;
          end else if (TO_EN) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (i_resp_ready) begin
            state        <= IDLE;
            o_resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_sb_apb_master_fsm.sv
// Bench for eth_sb_apb_master_fsm: scripted APB completer plus a
// transaction-level model checked on every falling edge.
module tb_eth_sb_apb_master_fsm;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_slverr, resp_timeout;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;
  logic [31:0] prdata;

  eth_sb_apb_master_fsm #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_write(req_write), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .i_req_strb(req_strb),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_rdata(resp_rdata), .o_resp_slverr(resp_slverr),
    .o_resp_timeout(resp_timeout),
    .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite),
    .o_paddr(paddr), .o_pwdata(pwdata), .o_pstrb(pstrb),
    .i_pready(pready), .i_pslverr(pslverr), .i_prdata(prdata)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Request being presented, plus its completer script.
  logic        rq_write;
  logic [31:0] rq_addr, rq_wdata, rq_prdata;
  logic [3:0]  rq_strb;
  logic        rq_err;
  int          rq_wait;

  // Accepted transaction and model predictions.
  logic        t_write;
  logic [31:0] t_addr, t_wdata, t_prdata;
  logic [3:0]  t_strb;
  logic        t_err;
  int          t_wait;
  int          exp_acc;
  logic [31:0] exp_rdata;
  logic        exp_slv, exp_to;

  bit          inflight = 0;
  bit          seen;
  int          cyc, acc;
  int          acc_cnt = 0, done_cnt = 0;
  int          h_lat, h_acc;
  logic [31:0] h_rdata;
  logic        h_slv, h_to;

  // Completer: pready on ACCESS cycle (wait+1); noise otherwise.
  int an = 0;
  always @(posedge clk) begin
    #1;
    if (psel && penable) begin
      an++;
      pready = (an == t_wait + 1);
    end else begin
      an = 0;
      pready = 1'b0;
    end
    pslverr = pready ? t_err : 1'b1;
    prdata  = pready ? t_prdata : $urandom;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      inflight = 0;
    end else begin
      chk("req_ready", req_ready, !inflight);
      chk("sel_resp_overlap", psel & resp_valid, 0);
      if (penable) chk("penable_wo_psel", psel, 1);
      if (psel) begin
        chk("paddr", paddr, t_addr);
        chk("pwrite", pwrite, t_write);
        chk("pwdata", pwdata, t_write ? t_wdata : 32'h0);
        chk("pstrb", pstrb, t_write ? t_strb : 4'h0);
      end
      if (inflight) begin
        cyc++;
        if (penable) acc++;
      end
      if (resp_valid) begin
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_slverr", resp_slverr, exp_slv);
        chk("resp_timeout", resp_timeout, exp_to);
        if (!seen) begin
          seen = 1;
          chk("access_cycles", acc, exp_acc);
          chk("latency", cyc, 2 + exp_acc);
        end
      end
      if (resp_valid && resp_ready) begin
        h_lat = cyc; h_acc = acc;
        h_rdata = resp_rdata; h_slv = resp_slverr;
        h_to = resp_timeout;
        inflight = 0;
        done_cnt++;
      end
      if (req_valid && req_ready) begin
        t_write = rq_write; t_addr = rq_addr;
        t_wdata = rq_wdata; t_strb = rq_strb;
        t_err = rq_err; t_wait = rq_wait;
        t_prdata = rq_prdata;
        if (t_wait < TO) begin
          exp_acc   = t_wait + 1;
          exp_rdata = t_write ? 32'h0 : t_prdata;
          exp_slv   = t_err;
          exp_to    = 1'b0;
        end else begin
          exp_acc   = TO;
          exp_rdata = 32'h0;
          exp_slv   = 1'b1;
          exp_to    = 1'b1;
        end
        inflight = 1; cyc = 0; acc = 0; seen = 0;
        acc_cnt++;
      end
    end
  end

  task automatic present(bit w, logic [31:0] a, logic [31:0] d,
                         logic [3:0] s, int wt, bit e,
                         logic [31:0] rd);
    rq_write = w; rq_addr = a; rq_wdata = d; rq_strb = s;
    rq_wait = wt; rq_err = e; rq_prdata = rd;
    req_write = w; req_addr = a; req_wdata = d; req_strb = s;
    req_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int n0 = acc_cnt;
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk); #1;
      ok = (acc_cnt != n0);
    end
    chk("accept_in_time", ok, 1);
    req_valid = 1'b0;
  endtask

  task automatic get_resp(int delay);
    int d0;
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk); #1;
      ok = resp_valid;
    end
    chk("resp_in_time", ok, 1);
    repeat (delay) begin @(posedge clk); #1; end
    resp_ready = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_handshake", done_cnt, d0 + 1);
  endtask

  task automatic send(bit w, logic [31:0] a, logic [31:0] d,
                      logic [3:0] s, int wt, bit e,
                      logic [31:0] rd);
    present(w, a, d, s, wt, e, rd);
    wait_accept();
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_write = 0; req_addr = 0; req_wdata = 0; req_strb = 0;
    t_wait = 0; t_err = 0; t_prdata = 0;
    pready = 0; pslverr = 0; prdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_rdata", resp_rdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", req_ready, 1);

    send(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0);
    get_resp(0);
    chk("wr_lat", h_lat, 3);
    chk("wr_acc", h_acc, 1);
    chk("wr_rdata", h_rdata, 0);
    chk("wr_slverr", h_slv, 0);

    send(0, 32'h24, 32'h12345678, 4'hA, 3, 0, 32'hCAFE0001);
    get_resp(0);
    chk("rd_rdata", h_rdata, 32'hCAFE0001);
    chk("rd_penable_cycles", h_acc, 4);
    chk("rd_lat", h_lat, 6);

    send(1, 32'h30, 32'h0BADF00D, 4'h3, 2, 1, 32'h0);
    get_resp(0);
    chk("err_slverr", h_slv, 1);
    chk("err_timeout", h_to, 0);

    send(0, 32'h40, 32'h0, 4'h0, 100, 0, 32'h55AA55AA);
    get_resp(0);
    chk("model_to_acc", exp_acc, 8);
    chk("to_acc", h_acc, 8);
    chk("to_slverr", h_slv, 1);
    chk("to_flag", h_to, 1);
    chk("to_rdata", h_rdata, 0);

    send(0, 32'h44, 32'h0, 4'h0, 7, 0, 32'h13572468);
    get_resp(0);
    chk("last_cycle_acc", h_acc, 8);
    chk("last_cycle_to", h_to, 0);
    chk("last_cycle_rdata", h_rdata, 32'h13572468);

    send(1, 32'h50, 32'hA5A5A5A5, 4'h5, 1, 0, 32'h0);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk); #1;
      ok = resp_valid;
    end
    chk("bp_resp_seen", ok, 1);
    present(0, 32'h58, 32'h0, 4'h0, 0, 0, 32'h600DCAFE);
    repeat (5) begin @(posedge clk); #1; end
    chk("bp_no_accept", acc_cnt, 6);
    get_resp(0);
    chk("bp_a_wdata_path", h_rdata, 0);
    wait_accept();
    get_resp(0);
    chk("bp_b_rdata", h_rdata, 32'h600DCAFE);
    chk("accept_count", acc_cnt, 7);

    send(0, 32'h60, 32'h0, 4'h0, 100, 0, 32'h0);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk); #1;
      ok = penable;
    end
    chk("rst_mid_reach_access", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_psel", psel, 0);
    chk("async_penable", penable, 0);
    chk("async_resp_valid", resp_valid, 0);
    chk("async_req_ready", req_ready, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_psel", psel, 0);
    chk("done_count", done_cnt, 7);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/eth_sb_apb_master_fsm.md
Name: eth_sb_apb_master_fsm

Overview:
APB initiator for the ETH sideband path. It accepts single-beat read/write requests from the sideband command side over a valid/ready handshake and drives an APB3/APB4 completer with the SETUP/ACCESS protocol. It returns read data and error status on a valid/ready response channel. A per-transfer timeout keeps a hung completer from stalling the sideband.

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width (strobe width DATA_WIDTH/8)
TIMEOUT_CYCLES, 256, maximum ACCESS cycles before abort; 0 disables the timeout

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_req_valid  in  1  request present
o_req_ready  out  1  request accepted when high with i_req_valid
i_req_write  in  1  1 = write, 0 = read
i_req_addr  in  ADDR_WIDTH  request address
i_req_wdata  in  DATA_WIDTH  write data
i_req_strb  in  DATA_WIDTH/8  write byte strobes
o_resp_valid  out  1  response present
i_resp_ready  in  1  response consumed
o_resp_rdata  out  DATA_WIDTH  read data (0 for writes)
o_resp_slverr  out  1  PSLVERR or timeout
o_resp_timeout  out  1  transfer aborted by timeout
o_psel  out  1  APB select
o_penable  out  1  APB enable
o_pwrite  out  1  APB direction
o_paddr  out  ADDR_WIDTH  APB address
o_pwdata  out  DATA_WIDTH  APB write data
o_pstrb  out  DATA_WIDTH/8  APB strobes
i_pready  in  1  completer ready
i_pslverr  in  1  completer error
i_prdata  in  DATA_WIDTH  completer read data

Behaviour:
- Interface decision: one clock, i_clk. i_reset_n is asynchronous, active-low.
- Reset: all outputs are 0 and the FSM is in IDLE. Reset takes effect immediately, even mid-transfer, so o_psel and o_penable drop without waiting for a clock edge. In-flight requests are discarded.
- All APB and response outputs are registered. o_req_ready is decoded from the state register.
- States: IDLE, SETUP, ACCESS, RESP. Encode as a 2-bit enum; unreachable encodings go to IDLE.
- IDLE: o_req_ready=1.
  - On i_req_valid & o_req_ready, capture the request and go to SETUP.
  - Next cycle: psel=1, penable=0, with paddr, pwrite, pwdata and pstrb valid.
  - For reads, pwdata=0 and pstrb=0.
- SETUP: lasts exactly one cycle, then ACCESS (psel=1, penable=1). Clear the timeout counter.
- ACCESS: paddr, pwrite, pwdata and pstrb stay stable.
  - On i_pready=1: capture i_prdata for reads (0 for writes) and capture i_pslverr into o_resp_slverr. Go to RESP. Next cycle psel=0, penable=0.
  - i_pslverr is sampled only when i_pready=1.
  - Timeout: the counter increments each ACCESS cycle with i_pready=0. When it equals TIMEOUT_CYCLES-1 with i_pready still 0, go to RESP with slverr=1, timeout=1, rdata=0. psel and penable drop.
  - i_pready on the same cycle as the timeout terminal count wins: normal completion, timeout=0.
  - Counter width is $clog2(TIMEOUT_CYCLES+1). It does not wrap. With TIMEOUT_CYCLES=0 the counter is held at 0.
- RESP: o_resp_valid=1, with rdata, slverr and timeout held stable until i_resp_ready. On the handshake, return to IDLE and clear o_resp_valid the next cycle.
- Latency: request accept to response valid is 3 cycles plus wait states. Minimum request spacing is 4 cycles.
- o_req_ready=0 outside IDLE. The requester must hold its request.

Decomposition:
- Package eth_sb_apb_pkg holds:
  - the apb_mst_state_e enum {IDLE, SETUP, ACCESS, RESP};
  - the default width and timeout localparams;
  - a req_t struct {write, addr, wdata, strb}.
- No sub-module is needed. The timeout counter stays inline.

Test Plan:
- Write, zero wait: req addr=0x10, wdata=0xDEADBEEF, strb=0xF, pready held 1 -> one SETUP cycle, one ACCESS cycle, resp_valid 3 cycles after accept, slverr=0, rdata=0.
- Read, 3 wait states: addr=0x24, pready after 3 ACCESS cycles with prdata=0xCAFE0001 -> penable high 4 cycles, paddr stable throughout, resp_rdata=0xCAFE0001, pstrb=0.
- Slave error: write with pslverr=1 on the pready cycle -> resp_slverr=1, timeout=0; pslverr=1 while pready=0 is ignored.
- Timeout: TIMEOUT_CYCLES=8, pready never asserted -> abort after 8 ACCESS cycles, slverr=1, timeout=1, rdata=0, psel low the next cycle. A second run with pready on the 8th cycle completes normally.
- Backpressure: resp_ready low for 5 cycles -> resp fields stable and req_ready=0 throughout. A new req_valid held during this is accepted only in IDLE, exactly once.
- Reset mid-ACCESS: deassert i_reset_n asynchronously -> psel, penable and resp_valid are 0 immediately. After release, the FSM is in IDLE and req_ready=1 on the first clock.
